// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes and memory-busy freezes.
// Optional macro STALL_COUNT_EN adds a saturating counter of cycles with the PC held.
`timescale 1ns/1ps
module pipeline_hazard_ctrl #(
   parameter int BRANCH_PENALTY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  rsIN,
   input  logic [4:0]  rtIN,
   input  logic [4:0]  rtExIN,
   input  logic        memReadExIN,
   input  logic        branchTakenIN,
   input  logic        memBusyIN,
   output logic        pcWriteOUT,
   output logic        ifidWriteOUT,
   output logic        ifidFlushOUT,
   output logic        idexFlushOUT,
   output logic [15:0] stallCountOUT
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      FLUSH   = 2'd1,
      MEMWAIT = 2'd2
   } state_t;

   localparam logic [1:0] LP_FLUSH_LOAD = 2'(BRANCH_PENALTY - 1);
   localparam bit         LP_HAS_FLUSH  = (BRANCH_PENALTY > 1);

   state_t     r_state;
   state_t     w_state_next;
   logic [1:0] r_cnt;
   logic [1:0] w_cnt_next;
   logic       r_pending;
   logic       w_pending_next;
   logic       r_ret_flush;
   logic       w_ret_flush_next;

   logic       w_lu;
   logic       w_serve_branch;
   logic       w_in_flush;
   logic       w_pc_write;
   logic       w_ifid_write;
   logic       w_ifid_flush;
   logic       w_idex_flush;

   assign w_lu = memReadExIN && (rtExIN != 5'd0) &&
                 ((rtExIN == rsIN) || (rtExIN == rtIN));

   // Leaving MEMWAIT behaves like whichever state was frozen, with a held branch first.
   assign w_serve_branch = branchTakenIN || ((r_state == MEMWAIT) && r_pending);
   assign w_in_flush     = (r_state == FLUSH) || ((r_state == MEMWAIT) && r_ret_flush);

   always_comb begin
      w_state_next     = r_state;
      w_cnt_next       = r_cnt;
      w_pending_next   = r_pending;
      w_ret_flush_next = r_ret_flush;
      w_pc_write       = 1'b0;
      w_ifid_write     = 1'b0;
      w_ifid_flush     = 1'b0;
      w_idex_flush     = 1'b0;

      if (memBusyIN) begin
         w_state_next     = MEMWAIT;
         w_pending_next   = r_pending | branchTakenIN;
         w_ret_flush_next = (r_state == MEMWAIT) ? r_ret_flush : (r_state == FLUSH);
      end else begin
         w_pending_next   = 1'b0;
         w_ret_flush_next = 1'b0;
         if (w_serve_branch) begin
            w_pc_write   = 1'b1;
            w_ifid_write = 1'b1;
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
            if (LP_HAS_FLUSH) begin
               w_state_next = FLUSH;
               w_cnt_next   = LP_FLUSH_LOAD;
            end else begin
               w_state_next = RUN;
               w_cnt_next   = 2'd0;
            end
         end else if (w_in_flush) begin
            w_pc_write   = 1'b1;
            w_ifid_write = 1'b1;
            w_ifid_flush = 1'b1;
            if (r_cnt <= 2'd1) begin
               w_state_next = RUN;
               w_cnt_next   = 2'd0;
            end else begin
               w_state_next = FLUSH;
               w_cnt_next   = r_cnt - 2'd1;
            end
         end else if (w_lu) begin
            w_idex_flush = 1'b1;
            w_state_next = RUN;
         end else begin
            w_pc_write   = 1'b1;
            w_ifid_write = 1'b1;
            w_state_next = RUN;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= RUN;
         r_cnt       <= 2'd0;
         r_pending   <= 1'b0;
         r_ret_flush <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_cnt       <= w_cnt_next;
         r_pending   <= w_pending_next;
         r_ret_flush <= w_ret_flush_next;
      end
   end

   // Reset overrides the controls immediately: hold the PC and inject bubbles everywhere.
   assign pcWriteOUT   = reset ? w_pc_write   : 1'b0;
   assign ifidWriteOUT = reset ? w_ifid_write : 1'b0;
   assign ifidFlushOUT = reset ? w_ifid_flush : 1'b1;
   assign idexFlushOUT = reset ? w_idex_flush : 1'b1;

`ifdef STALL_COUNT_EN
   logic [15:0] r_stall_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_cnt <= 16'h0000;
      end else if (!pcWriteOUT && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stallCountOUT = r_stall_cnt;
`else
   assign stallCountOUT = 16'h0000;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter BRANCH_PENALTY, default 1, the number of cycles IF_ID is flushed after a taken branch (legal range 1..3).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port rsIN  input  5  rs field of the instruction in ID.
REQ-005 SHALL have port rtIN  input  5  rt field of the instruction in ID.
REQ-006 SHALL have port rtExIN  input  5  destination rt of the instruction in EX.
REQ-007 SHALL have port memReadExIN  input  1  the instruction in EX is a load.
REQ-008 SHALL have port branchTakenIN  input  1  a branch or jump resolved taken this cycle.
REQ-009 SHALL have port memBusyIN  input  1  data memory not ready; the whole pipeline must freeze.
REQ-010 SHALL have port pcWriteOUT  output  1  PC register load enable.
REQ-011 SHALL have port ifidWriteOUT  output  1  IF_ID register load enable.
REQ-012 SHALL have port ifidFlushOUT  output  1  IF_ID loads a NOP (instruccion 32'h00000000).
REQ-013 SHALL have port idexFlushOUT  output  1  ID_EX loads a bubble (control bits zero).
REQ-014 SHALL have port stallCountOUT  output  16  count of cycles with pcWriteOUT=0.

Function
REQ-015 SHALL implement the states RUN, FLUSH and MEMWAIT.
REQ-016 SHALL define load-use hazard LU = memReadExIN and rtExIN!=0 and (rtExIN==rsIN or rtExIN==rtIN).
REQ-017 SHALL drive outputs combinationally from the current state and inputs (Mealy), so no cycle of latency exists between a hazard and its control.
REQ-018 SHALL give memBusyIN priority over branchTakenIN, and branchTakenIN priority over LU.
REQ-019 SHALL in RUN with memBusyIN=1 drive pcWrite=0, ifidWrite=0 and both flushes=0, then enter MEMWAIT.
REQ-020 SHALL in RUN with branchTakenIN=1 and memBusyIN=0 drive pcWrite=1, ifidWrite=1, ifidFlush=1 and idexFlush=1; with BRANCH_PENALTY>1 it SHALL enter FLUSH with the counter loaded to BRANCH_PENALTY-1, otherwise it SHALL stay in RUN.
REQ-021 SHALL in RUN with LU=1 and no higher-priority input drive pcWrite=0, ifidWrite=0, ifidFlush=0 and idexFlush=1 for that cycle, staying in RUN.
REQ-022 SHALL in RUN with no event drive pcWrite=1, ifidWrite=1 and both flushes=0.
REQ-023 SHALL in FLUSH drive pcWrite=1, ifidWrite=1, ifidFlush=1 and idexFlush=0, decrement the 2-bit counter each cycle, and return to RUN after the cycle in which the counter reaches 0; LU SHALL be ignored in FLUSH.
REQ-024 SHALL in FLUSH with memBusyIN=1 freeze the counter, drive all enables and flushes to 0, and enter MEMWAIT with return-to-FLUSH recorded.
REQ-025 SHALL in MEMWAIT drive pcWrite=0, ifidWrite=0 and both flushes=0 while memBusyIN=1.
REQ-026 SHALL latch branchTakenIN=1, when seen together with memBusyIN=1, into a pending flag; on the first cycle with memBusyIN=0, a set flag SHALL be served exactly as REQ-020 and then cleared.
REQ-027 SHALL leave MEMWAIT on the first cycle with memBusyIN=0, acting in that cycle as the resume target (RUN, FLUSH or pending branch) would.

Reset
REQ-028 SHALL, while reset=0, force state RUN, the counter to 0, the pending flag to 0 and stallCountOUT to 0, and drive pcWrite=0, ifidWrite=0, ifidFlush=1 and idexFlush=1.
REQ-029 SHALL abort any FLUSH, MEMWAIT or pending branch when reset is asserted mid-operation, and resume in RUN on the first edge after release.

Configuration
REQ-030 SHALL, with STALL_COUNT_EN defined, increment stallCountOUT on every clock edge where pcWriteOUT=0 (reset excluded), saturating at 16'hFFFF.
REQ-031 SHALL, without STALL_COUNT_EN, tie stallCountOUT to 16'h0000 and instantiate no counter logic.

Verification
REQ-032 SHALL cover: memReadExIN=1, rtExIN=5, rsIN=5 for one cycle -> pcWrite=0, ifidWrite=0, idexFlush=1 for exactly that cycle; rtExIN=0 -> no stall.
REQ-033 SHALL cover: branchTakenIN=1 with BRANCH_PENALTY=3 -> ifidFlush=1 for 3 consecutive cycles, idexFlush=1 only in the first.
REQ-034 SHALL cover: memBusyIN=1 for 4 cycles with branchTakenIN=1 in cycle 1 -> enables 0 for 4 cycles, then the branch flush is served in cycle 5.
REQ-035 SHALL cover: LU together with branchTakenIN in the same cycle -> branch response only (pcWrite=1, both flushes=1).
REQ-036 SHALL cover: reset asserted during FLUSH -> outputs immediately take reset values, RUN after release; with STALL_COUNT_EN, 70000 stall cycles -> stallCountOUT=16'hFFFF.
